// File: rtl/cpu_sequencer.sv
// Instruction-cycle sequencer: owns the microcode cycle counter, gates the datapath
// via cpu_en, and adds run/pause/step debug control, a PC breakpoint and a watchdog.
module cpu_sequencer #(
    parameter logic [3:0]  STATE_NEXT = 4'h2,
    parameter logic [3:0]  STATE_HALT = 4'h1,
    parameter int unsigned MAX_CYCLES = 7,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       state,
    input  logic [7:0]       pc,
    input  logic             run_en,
    input  logic             step_req,
    input  logic             bp_en,
    input  logic [7:0]       bp_addr,
    output logic [3:0]       cycle,
    output logic             cpu_en,
    output logic             paused,
    output logic             halted,
    output logic             fault,
    output logic [CNT_W-1:0] instr_count
);

    localparam int unsigned CYC_W = 4;
    localparam logic [CYC_W-1:0] LAST_CYCLE = CYC_W'(MAX_CYCLES - 1);

    typedef enum logic [2:0] {
        S_PAUSE = 3'd0,
        S_RUN   = 3'd1,
        S_STEP  = 3'd2,
        S_HALT  = 3'd3,
        S_FAULT = 3'd4
    } seq_state_e;

    seq_state_e fsm;
    seq_state_e fsm_nxt;
    logic       bp_armed;
    logic       bp_hit;
    logic       retire;
    logic       halt_hit;
    logic       fault_hit;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            fsm <= S_PAUSE;
        end else begin
            fsm <= fsm_nxt;
        end
    end

    // Next-state: halt > watchdog > breakpoint > retire > run_en/step
    always_comb begin
        fsm_nxt = fsm;
        case (fsm)
            S_PAUSE: begin
                if (run_en) begin
                    fsm_nxt = S_RUN;
                end else if (step_req) begin
                    fsm_nxt = S_STEP;
                end
            end
            S_RUN: begin
                if (halt_hit) begin
                    fsm_nxt = S_HALT;
                end else if (fault_hit) begin
                    fsm_nxt = S_FAULT;
                end else if (bp_hit) begin
                    fsm_nxt = S_PAUSE;
                end else if (retire && !run_en) begin
                    fsm_nxt = S_PAUSE;
                end
            end
            S_STEP: begin
                if (halt_hit) begin
                    fsm_nxt = S_HALT;
                end else if (fault_hit) begin
                    fsm_nxt = S_FAULT;
                end else if (retire) begin
                    fsm_nxt = S_PAUSE;
                end
            end
            S_HALT:  fsm_nxt = S_HALT;
            S_FAULT: fsm_nxt = S_FAULT;
            default: fsm_nxt = S_PAUSE;
        endcase
    end

    // Outputs and event decode from the registered state
    always_comb begin
        bp_hit    = 1'b0;
        cpu_en    = 1'b0;
        retire    = 1'b0;
        halt_hit  = 1'b0;
        fault_hit = 1'b0;
        paused    = (fsm == S_PAUSE);
        halted    = (fsm == S_HALT);
        fault     = (fsm == S_FAULT);

        bp_hit    = (fsm == S_RUN) && bp_en && bp_armed &&
                    (cycle == '0) && (pc == bp_addr);
        cpu_en    = ((fsm == S_RUN) || (fsm == S_STEP)) && !bp_hit;
        retire    = cpu_en && (state == STATE_NEXT);
        halt_hit  = cpu_en && (state == STATE_HALT);
        fault_hit = cpu_en && (cycle == LAST_CYCLE) &&
                    (state != STATE_NEXT) && (state != STATE_HALT);
    end

    // Cycle counter, retired count and breakpoint arming; cycle freezes on halt/fault entry
    always_ff @(posedge clk) begin
        if (reset) begin
            cycle       <= '0;
            instr_count <= '0;
            bp_armed    <= 1'b1;
        end else begin
            if (retire) begin
                cycle       <= '0;
                instr_count <= instr_count + CNT_W'(1);
                bp_armed    <= 1'b1;
            end else if (cpu_en && !halt_hit && !fault_hit) begin
                cycle <= cycle + CYC_W'(1);
            end
            if (bp_hit) begin
                bp_armed <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer with a small decoder model closing the cycle/state loop.
module tb_cpu_sequencer;

    localparam logic [3:0] STATE_NEXT = 4'h2;
    localparam logic [3:0] STATE_HALT = 4'h1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  state;
    logic [7:0]  pc;
    logic        run_en = 1'b0;
    logic        step_req = 1'b0;
    logic        bp_en = 1'b0;
    logic [7:0]  bp_addr = 8'h00;
    logic [3:0]  cycle;
    logic        cpu_en;
    logic        paused;
    logic        halted;
    logic        fault;
    logic [15:0] instr_count;

    int ret_cyc  = -1;
    int halt_cyc = -1;
    int n_tests  = 0;
    int n_fail   = 0;

    cpu_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .state       (state),
        .pc          (pc),
        .run_en      (run_en),
        .step_req    (step_req),
        .bp_en       (bp_en),
        .bp_addr     (bp_addr),
        .cycle       (cycle),
        .cpu_en      (cpu_en),
        .paused      (paused),
        .halted      (halted),
        .fault       (fault),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    // Decoder model: retire / halt at a chosen cycle index, program counter follows retirements
    always_comb begin
        state = 4'h0;
        if (int'(cycle) == ret_cyc)  state = STATE_NEXT;
        if (int'(cycle) == halt_cyc) state = STATE_HALT;
    end
    assign pc = instr_count[7:0];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        // Reset state
        tick();
        reset = 1'b0;
        check("rst_paused", 32'(paused), 32'd1);
        check("rst_cycle", 32'(cycle), 32'd0);
        check("rst_count", 32'(instr_count), 32'd0);
        check("rst_cpu_en", 32'(cpu_en), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_fault", 32'(fault), 32'd0);

        // Free run, retire at cycle 4
        ret_cyc = 4;
        run_en  = 1'b1;
        tick();
        for (int i = 0; i < 15; i++) begin
            check("t1_cycle", 32'(cycle), 32'(i % 5));
            check("t1_cpu_en", 32'(cpu_en), 32'd1);
            tick();
        end
        check("t1_count", 32'(instr_count), 32'd3);
        check("t1_cycle_end", 32'(cycle), 32'd0);

        // Halt at cycle 2, sticky until reset
        halt_cyc = 2;
        tick();
        tick();
        check("t2_cpu_en_pre", 32'(cpu_en), 32'd1);
        tick();
        check("t2_halted", 32'(halted), 32'd1);
        check("t2_cpu_en", 32'(cpu_en), 32'd0);
        check("t2_cycle", 32'(cycle), 32'd2);
        run_en   = 1'b0;
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        run_en   = 1'b1;
        tick();
        check("t2_sticky", 32'(halted), 32'd1);
        check("t2_cycle_hold", 32'(cycle), 32'd2);
        check("t2_count", 32'(instr_count), 32'd3);
        halt_cyc = -1;
        run_en   = 1'b0;
        do_reset();
        check("t2_rst_paused", 32'(paused), 32'd1);
        check("t2_rst_cycle", 32'(cycle), 32'd0);
        check("t2_rst_count", 32'(instr_count), 32'd0);

        // Breakpoint at pc 5, then single step past it
        bp_en   = 1'b1;
        bp_addr = 8'h05;
        run_en  = 1'b1;
        tick();
        repeat (25) tick();
        check("t3_bp_cpu_en", 32'(cpu_en), 32'd0);
        check("t3_bp_cycle", 32'(cycle), 32'd0);
        run_en = 1'b0;
        tick();
        check("t3_paused", 32'(paused), 32'd1);
        check("t3_count", 32'(instr_count), 32'd5);
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        check("t3_step_cpu_en", 32'(cpu_en), 32'd1);
        repeat (5) tick();
        check("t3_step_paused", 32'(paused), 32'd1);
        check("t3_step_count", 32'(instr_count), 32'd6);
        check("t3_step_cycle", 32'(cycle), 32'd0);

        // Seven-cycle step; a second step_req mid-step is ignored
        bp_en   = 1'b0;
        ret_cyc = 6;
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        for (int i = 0; i < 7; i++) begin
            check("t4_cpu_en", 32'(cpu_en), 32'd1);
            step_req = (i == 2);
            tick();
        end
        step_req = 1'b0;
        check("t4_paused", 32'(paused), 32'd1);
        check("t4_cycle", 32'(cycle), 32'd0);
        check("t4_count", 32'(instr_count), 32'd7);
        check("t4_cpu_en_off", 32'(cpu_en), 32'd0);
        tick();
        check("t4_still_paused", 32'(paused), 32'd1);
        check("t4_count_hold", 32'(instr_count), 32'd7);

        // Watchdog: never retire
        ret_cyc = -1;
        run_en  = 1'b1;
        tick();
        repeat (6) tick();
        check("t5_cycle6", 32'(cycle), 32'd6);
        check("t5_no_fault_yet", 32'(fault), 32'd0);
        tick();
        check("t5_fault", 32'(fault), 32'd1);
        check("t5_cpu_en", 32'(cpu_en), 32'd0);
        check("t5_cycle_frozen", 32'(cycle), 32'd6);
        run_en   = 1'b0;
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        check("t5_sticky", 32'(fault), 32'd1);
        do_reset();
        check("t5_rst_fault", 32'(fault), 32'd0);
        check("t5_rst_paused", 32'(paused), 32'd1);

        // Halt at the last legal cycle wins over the watchdog
        halt_cyc = 6;
        run_en   = 1'b1;
        tick();
        repeat (6) tick();
        tick();
        check("hf_halted", 32'(halted), 32'd1);
        check("hf_fault", 32'(fault), 32'd0);
        check("hf_cycle", 32'(cycle), 32'd6);
        halt_cyc = -1;
        run_en   = 1'b0;
        do_reset();

        // run_en dropped mid-instruction: instruction completes, then pause
        ret_cyc = 4;
        run_en  = 1'b1;
        tick();
        tick();
        tick();
        run_en = 1'b0;
        tick();
        check("t6_cycle3", 32'(cycle), 32'd3);
        check("t6_cpu_en", 32'(cpu_en), 32'd1);
        tick();
        tick();
        check("t6_paused", 32'(paused), 32'd1);
        check("t6_cycle0", 32'(cycle), 32'd0);
        check("t6_count", 32'(instr_count), 32'd1);

        // Reset mid-instruction abandons it
        run_en = 1'b1;
        tick();
        repeat (3) tick();
        check("t6_mid_cycle", 32'(cycle), 32'd3);
        run_en = 1'b0;
        do_reset();
        check("t6_rst_cycle", 32'(cycle), 32'd0);
        check("t6_rst_paused", 32'(paused), 32'd1);
        check("t6_rst_count", 32'(instr_count), 32'd0);

        // Retired counter wraps from all-ones to zero
        ret_cyc = 0;
        run_en  = 1'b1;
        tick();
        repeat (65535) @(posedge clk);
        #1;
        check("wrap_ffff", 32'(instr_count), 32'h0000_FFFF);
        tick();
        check("wrap_zero", 32'(instr_count), 32'd0);
        check("wrap_cycle", 32'(cycle), 32'd0);
        run_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
